// File: rtl/float_add_seq.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes.
// One operation in flight; truncating rounding, no denormals.
module float_add_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         unf
);

    localparam int FW = MAN_W + 1;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(FW + 1);

    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W:0] SH_MAX = (EXP_W + 1)'(MAN_W + 2);
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W - 1){1'b0}}};
    localparam logic signed [XW-1:0] EMAX_S = $signed({2'b00, EMAX});
    localparam logic signed [XW-1:0] EZERO = '0;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    state_t state, state_n;

    logic [W-1:0]     a_r, b_r;
    logic             special_r;
    logic [EXP_W-1:0] x_e;
    logic [FW-1:0]    f_big, f_small;
    logic             s_big, s_small;
    logic [FW-1:0]    w_m;
    logic [XW-1:0]    w_e;
    logic             w_s;
    logic [W-1:0]     result_r;
    logic             ovf_r, unf_r;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (in_valid) state_n = ALIGN;
            ALIGN:   state_n = ADD;
            ADD:     state_n = NORM;
            NORM:    state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign unf       = unf_r;

    // Operand field decode (b_r already carries the subtract inversion)
    logic             a_s, b_s;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W-1:0] a_m, b_m;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign a_s = a_r[W-1];
    assign b_s = b_r[W-1];
    assign a_e = a_r[W-2 -: EXP_W];
    assign b_e = b_r[W-2 -: EXP_W];
    assign a_m = a_r[MAN_W-1:0];
    assign b_m = b_r[MAN_W-1:0];

    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (a_e == EMAX) && (a_m == '0);
    assign b_inf  = (b_e == EMAX) && (b_m == '0);
    assign a_nan  = (a_e == EMAX) && (a_m != '0);
    assign b_nan  = (b_e == EMAX) && (b_m != '0);

    logic         spec_hit;
    logic [W-1:0] spec_val;

    always_comb begin
        spec_hit = 1'b1;
        spec_val = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) spec_val = QNAN;
        else if (a_inf)             spec_val = a_r;
        else if (b_inf)             spec_val = b_r;
        else if (a_zero && b_zero)  spec_val = '0;
        else if (a_zero)            spec_val = b_r;
        else if (b_zero)            spec_val = a_r;
        else                        spec_hit = 1'b0;
    end

    logic             a_big;
    logic [EXP_W-1:0] diff;
    logic [FW-1:0]    big_f, small_f, sh_f;

    always_comb begin
        a_big   = (a_e >= b_e);
        diff    = a_big ? (a_e - b_e) : (b_e - a_e);
        big_f   = a_big ? {1'b1, a_m} : {1'b1, b_m};
        small_f = a_big ? {1'b1, b_m} : {1'b1, a_m};
        // Guard large differences explicitly so the shift can never wrap
        if ({1'b0, diff} >= SH_MAX) sh_f = '0;
        else                        sh_f = small_f >> diff;
    end

    logic [FW:0]   sum;
    logic [FW-1:0] add_m;
    logic [XW-1:0] add_e;
    logic          add_s;

    always_comb begin
        sum   = {1'b0, f_big} + {1'b0, f_small};
        add_m = '0;
        add_e = {2'b00, x_e};
        add_s = s_big;
        if (s_big == s_small) begin
            if (sum[FW]) begin
                add_m = sum[FW:1];
                add_e = {2'b00, x_e} + XW'(1);
            end else begin
                add_m = sum[FW-1:0];
            end
        end else if (f_big >= f_small) begin
            add_m = f_big - f_small;
        end else begin
            add_m = f_small - f_big;
            add_s = s_small;
        end
    end

    logic [LW-1:0]          lz;
    logic [MAN_W-1:0]       n_m;
    logic signed [XW-1:0]   n_e;
    logic [W-1:0]           norm_val;
    logic                   norm_ovf, norm_unf;

    always_comb begin
        lz = '0;
        for (int i = 0; i < FW; i++) begin
            if (w_m[i]) lz = LW'(FW - 1 - i);
        end
        n_m      = w_m[MAN_W-1:0] << lz;
        n_e      = $signed(w_e - XW'(lz));
        norm_val = '0;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (w_m == '0) begin
            norm_val = '0;
        end else if (n_e >= EMAX_S) begin
            norm_val = {w_s, EMAX, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (n_e <= EZERO) begin
            norm_unf = 1'b1;
        end else begin
            norm_val = {w_s, n_e[EXP_W-1:0], n_m};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            special_r <= 1'b0;
            x_e       <= '0;
            f_big     <= '0;
            f_small   <= '0;
            s_big     <= 1'b0;
            s_small   <= 1'b0;
            w_m       <= '0;
            w_e       <= '0;
            w_s       <= 1'b0;
            result_r  <= '0;
            ovf_r     <= 1'b0;
            unf_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= op_a;
                        b_r   <= {op_b[W-1] ^ sub, op_b[W-2:0]};
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                    end
                end
                ALIGN: begin
                    special_r <= spec_hit;
                    if (spec_hit) result_r <= spec_val;
                    x_e     <= a_big ? a_e : b_e;
                    f_big   <= big_f;
                    f_small <= sh_f;
                    s_big   <= a_big ? a_s : b_s;
                    s_small <= a_big ? b_s : a_s;
                end
                ADD: begin
                    w_m <= add_m;
                    w_e <= add_e;
                    w_s <= add_s;
                end
                NORM: begin
                    if (!special_r) begin
                        result_r <= norm_val;
                        ovf_r    <= norm_ovf;
                        unf_r    <= norm_unf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_add_seq.sv
// Scoreboard bench for float_add_seq: single-precision build plus a
// mini-float (EXP_W=4, MAN_W=3) instance.
module tb_float_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_ready, sub;
    logic        out_valid, out_ready, ovf, unf;
    logic [31:0] op_a, op_b, result;

    logic       m_in_valid, m_in_ready, m_out_valid, m_ovf, m_unf;
    logic [7:0] m_op_a, m_op_b, m_result;

    int checks = 0;
    int errors = 0;

    logic [33:0] sb[$];
    logic [33:0] mon_exp;

    float_add_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .unf(unf)
    );

    float_add_seq #(.EXP_W(4), .MAN_W(3)) mini (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .op_a(m_op_a), .op_b(m_op_b), .sub(1'b0),
        .out_valid(m_out_valid), .out_ready(1'b1),
        .result(m_result), .ovf(m_ovf), .unf(m_unf)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                check("result", 64'(result), 64'(mon_exp[31:0]));
                check("ovf", 64'(ovf), 64'(mon_exp[33]));
                check("unf", 64'(unf), 64'(mon_exp[32]));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [31:0] r,
                         input logic o, input logic u);
        @(negedge clk);
        wait_ready();
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back({o, u, r});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        sub = 1'b0;
        op_a = '0;
        op_b = '0;
        m_in_valid = 1'b0;
        m_op_a = '0;
        m_op_b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_unf", 64'(unf), 64'd0);

        // latency of first operation: 1.0 + 2.0
        op_a = 32'h3F800000;
        op_b = 32'h40000000;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back({2'b00, 32'h40400000});
        lat = 1;
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", 64'(lat), 64'd4);
        drain();

        do_op(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b0);
        do_op(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        do_op(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        do_op(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        do_op(32'h00C00000, 32'h80800000, 1'b0, 32'h00000000, 1'b0, 1'b1);
        do_op(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0);
        do_op(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        do_op(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1'b0, 1'b0);
        do_op(32'h40400000, 32'h00000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        do_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        do_op(32'h40A00000, 32'h40E00000, 1'b1, 32'hC0000000, 1'b0, 1'b0);
        do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        drain();

        // back-pressure: hold the result in DONE for 5 cycles
        @(negedge clk);
        out_ready = 1'b0;
        do_op(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op_a = $urandom;
            op_b = $urandom;
            in_valid = 1'b1;
            check("stall_result", 64'(result), 64'h40000000);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_idle", 64'(in_ready), 64'd1);
        do_op(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        drain();

        // reset during ADD discards the operation
        @(negedge clk);
        wait_ready();
        op_a = 32'h3F800000;
        op_b = 32'h3F800000;
        sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result", 64'(result), 64'd0);
        do_op(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0);
        drain();

        // mini-float build: 1.0 + 2.0
        @(negedge clk);
        m_op_a = 8'h38;
        m_op_b = 8'h40;
        m_in_valid = 1'b1;
        @(posedge clk);
        #1 m_in_valid = 1'b0;
        n = 0;
        while (!m_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mini_valid", 64'(m_out_valid), 64'd1);
        check("mini_result", 64'(m_result), 64'h44);
        check("mini_ovf", 64'(m_ovf), 64'd0);
        check("mini_unf", 64'(m_unf), 64'd0);
        check("mini_in_ready", 64'(m_in_ready), 64'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
